// File: rtl/ram_port_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// ram_port_arbiter_pkg
//   Shared types and defaults for the data-RAM port arbiter.
//   - arb_state_t    : arbitration FSM state encoding (2 bits)
//   - DEF_ADDR_BITS  : default RAM byte-address width
//   - DEF_MAX_WAIT   : default number of debug denials before a forced grant
//   - WAIT_CNT_BITS  : width of the starvation counter (holds up to 15)
//   - word_addr_bits : word-address width derived from a byte-address width
// ----------------------------------------------------------------------------
package ram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FORCE = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    localparam int DEF_ADDR_BITS = 12;
    localparam int DEF_MAX_WAIT  = 4;
    localparam int WAIT_CNT_BITS = 4;

    // RAM is word-organised; the two byte-offset bits are dropped.
    function automatic int word_addr_bits(input int addr_bits);
        return addr_bits - 2;
    endfunction

endpackage

// File: rtl/ram_port_arbiter.sv
// ----------------------------------------------------------------------------
// ram_port_arbiter
//   Shares the single data-RAM port between the CPU memory stage (fixed
//   priority, read/write) and the display/debug reader (read-only). After
//   MAX_WAIT consecutive debug denials the next cycle is handed to debug and
//   the CPU is stalled for exactly that one cycle.
//
// Parameters
//   ADDR_BITS  RAM byte-address bits (word address is ADDR_BITS-2 wide)
//   MAX_WAIT   consecutive debug denials before a forced grant, 1..15
//
// Ports
//   clk, rst                 clock; synchronous active-high reset
//   cpu_req/rw/sel/extend_type/addr/wdata   CPU access request
//   cpu_gnt, cpu_stall       CPU owns the port / CPU must freeze and retry
//   cpu_rdata                load data, valid when cpu_gnt=1
//   dbg_req, dbg_addr        debug read request, held until dbg_valid
//   dbg_gnt                  debug owns the port this cycle
//   dbg_valid, dbg_rdata     one-cycle pulse with the registered read data
//   ram_rw/sel/extend_type/addr/data_in     muxed RAM port
//   ram_data_out             combinational RAM read data
//   stall_cycles             count of cpu_stall cycles, wraps at 2^32
// ----------------------------------------------------------------------------
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int ADDR_BITS = DEF_ADDR_BITS,
    parameter int MAX_WAIT  = DEF_MAX_WAIT
) (
    input  logic                                clk,
    input  logic                                rst,

    input  logic                                cpu_req,
    input  logic                                cpu_rw,
    input  logic [3:0]                          cpu_sel,
    input  logic                                cpu_extend_type,
    input  logic [word_addr_bits(ADDR_BITS)-1:0] cpu_addr,
    input  logic [31:0]                         cpu_wdata,
    output logic                                cpu_gnt,
    output logic                                cpu_stall,
    output logic [31:0]                         cpu_rdata,

    input  logic                                dbg_req,
    input  logic [word_addr_bits(ADDR_BITS)-1:0] dbg_addr,
    output logic                                dbg_gnt,
    output logic                                dbg_valid,
    output logic [31:0]                         dbg_rdata,

    output logic                                ram_rw,
    output logic [3:0]                          ram_sel,
    output logic                                ram_extend_type,
    output logic [word_addr_bits(ADDR_BITS)-1:0] ram_addr,
    output logic [31:0]                         ram_data_in,
    input  logic [31:0]                         ram_data_out,

    output logic [31:0]                         stall_cycles
);

    localparam logic [WAIT_CNT_BITS-1:0] MAX_WAIT_CNT = WAIT_CNT_BITS'(MAX_WAIT);

    arb_state_t               state;
    logic [WAIT_CNT_BITS-1:0] wait_cnt;
    logic [WAIT_CNT_BITS-1:0] wait_next;

    assign wait_next = wait_cnt + 1'b1;
    assign cpu_rdata = ram_data_out;

    // Grant decode. Grants are combinational so the winner uses the port in
    // the same cycle it asks; everything is held off while rst is high so no
    // write can slip into RAM during reset.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        dbg_gnt   = 1'b0;
        cpu_gnt   = 1'b0;
        cpu_stall = 1'b0;
        if (!rst) begin
            case (state)
                ST_IDLE, ST_WAIT: dbg_gnt = dbg_req & ~cpu_req;
                ST_FORCE:         dbg_gnt = 1'b1;
                default:          dbg_gnt = 1'b0;   // DONE: no second grant
            endcase
            cpu_gnt   = cpu_req & (state != ST_FORCE);
            cpu_stall = cpu_req & (state == ST_FORCE);
        end
    end

    // RAM port mux. ram_rw is only ever taken from the CPU under cpu_gnt,
    // so a write presented during a forced debug cycle never reaches RAM.
    always_comb begin
        ram_rw          = 1'b0;
        ram_sel         = 4'b0000;
        ram_extend_type = 1'b0;
        ram_addr        = '0;
        ram_data_in     = 32'd0;
        if (cpu_gnt) begin
            ram_rw          = cpu_rw;
            ram_sel         = cpu_sel;
            ram_extend_type = cpu_extend_type;
            ram_addr        = cpu_addr;
            ram_data_in     = cpu_wdata;
        end else if (dbg_gnt) begin
            ram_sel  = 4'b1111;
            ram_addr = dbg_addr;
        end
    end

    // Arbitration FSM, starvation counter, debug read capture and stall
    // statistic.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state        <= ST_IDLE;
            wait_cnt     <= '0;
            dbg_valid    <= 1'b0;
            dbg_rdata    <= 32'd0;
            stall_cycles <= 32'd0;
        end else begin
            // The read is captured at the end of the grant cycle, so the
            // valid pulse lands exactly in the following (DONE) cycle.
            dbg_valid <= dbg_gnt;
            if (dbg_gnt) begin
                dbg_rdata <= ram_data_out;
            end
            if (cpu_stall) begin
                stall_cycles <= stall_cycles + 32'd1;
            end

            case (state)
                ST_IDLE: begin
                    if (dbg_req) begin
                        if (!cpu_req) begin
                            state <= ST_DONE;
                        end else begin
                            wait_cnt <= WAIT_CNT_BITS'(1);
                            state    <= (MAX_WAIT_CNT == WAIT_CNT_BITS'(1)) ? ST_FORCE : ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!dbg_req) begin
                        // Requester gave up; the next request starts fresh.
                        state    <= ST_IDLE;
                        wait_cnt <= '0;
                    end else if (!cpu_req) begin
                        state <= ST_DONE;
                    end else begin
                        wait_cnt <= wait_next;
                        if (wait_next == MAX_WAIT_CNT) begin
                            state <= ST_FORCE;
                        end
                    end
                end
                ST_FORCE: begin
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    // dbg_req is still high here; returning to IDLE lets a
                    // new request be arbitrated normally next cycle.
                    state    <= ST_IDLE;
                    wait_cnt <= '0;
                end
                default: begin
                    state    <= ST_IDLE;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

endmodule
